vga_plot_arbiter: RTL and testbench
===================================

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter: X_W, 9, pixel X coordinate width.
REQ-002 Parameter: Y_W, 8, pixel Y coordinate width.
REQ-003 Parameter: C_W, 3, pixel colour width.
REQ-004 Port: clock  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-006 Port: req  input  3  burst request per requester; 0=animation, 1=map, 2=sprite.
REQ-007 Port: last  input  3  per-requester end-of-burst marker, valid with plot_in.
REQ-008 Port: plot_in  input  3  per-requester pixel-write strobe.
REQ-009 Port: x_in  input  3*X_W  packed X; requester i occupies [X_W*i +: X_W].
REQ-010 Port: y_in  input  3*Y_W  packed Y; same packing.
REQ-011 Port: color_in  input  3*C_W  packed colour; same packing.
REQ-012 Port: grant  output  3  registered one-hot grant, or all zero.
REQ-013 Port: plot  output  1  registered pixel-write strobe to the VGA adapter.
REQ-014 Port: X, Y, color  output  X_W, Y_W, C_W  registered pixel coordinate and colour.
REQ-015 Port: busy  output  1  high while any grant is held.
REQ-016 Port: wd_timeout  output  1  one-cycle pulse on watchdog revocation.

Function
REQ-017 The block SHALL implement FSM states IDLE, GRANT and GAP.
REQ-018 In IDLE with any req bit high, it SHALL latch the lowest-index requester, enter GRANT, and assert grant[i] on the next cycle.
REQ-019 In IDLE with req=0, it SHALL remain in IDLE with grant=0.
REQ-020 In GRANT, for each cycle t with req[i]&plot_in[i] high, plot SHALL be 1 at t+1, with X/Y/color equal to requester i's slice at t.
REQ-021 Strobes from non-granted requesters SHALL be ignored and never reach plot.
REQ-022 A higher-priority req arriving during GRANT SHALL NOT preempt; burst ends only per REQ-023/REQ-024 (or REQ-032).
REQ-023 plot_in[i]&last[i] in GRANT SHALL forward that pixel and move the FSM to GAP.
REQ-024 req[i] low in GRANT SHALL discard that cycle's plot_in[i] and move the FSM to GAP.
REQ-025 GAP SHALL last exactly one cycle with grant=0 and plot=0, then go to IDLE; the minimum inter-burst idle gap is therefore 2 cycles.
REQ-026 X, Y and color SHALL hold their last values while plot=0.
REQ-027 busy SHALL equal 1 exactly when grant is non-zero.

Reset
REQ-028 resetn low SHALL asynchronously force state=IDLE and grant, plot, X, Y, color, busy, wd_timeout and the watchdog counter to 0.
REQ-029 Reset mid-burst SHALL drop the grant with no further plot; after release, arbitration restarts from IDLE.

Configuration
REQ-030 Macro VGA_ARB_WATCHDOG_EN SHALL select whether the grant watchdog is compiled in.
REQ-031 With the macro defined, a 12-bit counter SHALL clear on entering GRANT and on every forwarded pixel, and increment on every other GRANT cycle.
REQ-032 With the macro defined, when the counter reaches 4095 the FSM SHALL enter GAP and pulse wd_timeout for one cycle.
REQ-033 Without the macro, no counter SHALL exist, wd_timeout SHALL be tied 0, and a grant SHALL be held indefinitely.

Verification
REQ-034 req=3'b110 at cycle 0 -> grant=3'b010 at cycle 1; map pixel X=5, Y=7, color=3'b100 strobed at cycle 2 -> plot=1, X=5, Y=7, color=4 at cycle 3.
REQ-035 Sprite granted; req[0] rises mid-burst -> grant stays 3'b100 until sprite last; then GAP, IDLE, grant=3'b001.
REQ-036 Map granted while sprite strobes plot_in[2] with X=100 -> plot stays 0 for those cycles.
REQ-037 resetn pulsed low during a 10-pixel map burst -> all outputs 0 immediately, no further plot, grant=0 until req is re-sampled in IDLE.
REQ-038 Macro on; animation granted, no plot_in for 4095 cycles -> wd_timeout=1 for one cycle, grant=0 for the following cycle. Macro off, same stimulus -> grant held and wd_timeout stays 0.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Arbitrates three pixel-writer requesters onto one VGA adapter port, with fixed priority and no preemption.
// Latency: the grant appears 1 cycle after req is sampled in IDLE; a pixel appears 1 cycle after its strobe.
// Backpressure: none; strobes from requesters that are not granted are dropped. Optional watchdog macro: VGA_ARB_WATCHDOG_EN.
module vga_plot_arbiter #(
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int C_W = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [2:0]       req,
    input  logic [2:0]       last,
    input  logic [2:0]       plot_in,
    input  logic [3*X_W-1:0] x_in,
    input  logic [3*Y_W-1:0] y_in,
    input  logic [3*C_W-1:0] color_in,
    output logic [2:0]       grant,
    output logic             plot,
    output logic [X_W-1:0]   X,
    output logic [Y_W-1:0]   Y,
    output logic [C_W-1:0]   color,
    output logic             busy,
    output logic             wd_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [2:0]     grant_q, grant_d;
    logic           plot_q, plot_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [C_W-1:0] color_q, color_d;
    logic           wd_q, wd_d;

    // Signals of the currently granted requester (all zero when nobody holds the grant)
    logic           sel_req, sel_plot, sel_last;
    logic [X_W-1:0] sel_x;
    logic [Y_W-1:0] sel_y;
    logic [C_W-1:0] sel_color;
    logic           wd_fire;

    // Route the granted requester's strobe, marker and pixel fields through a one-hot mux
    always_comb begin
        sel_req   = |(req & grant_q);
        sel_plot  = |(plot_in & grant_q);
        sel_last  = |(last & grant_q);
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant_q[i]) begin
                sel_x     = x_in[X_W*i +: X_W];
                sel_y     = y_in[Y_W*i +: Y_W];
                sel_color = color_in[C_W*i +: C_W];
            end
        end
    end

`ifdef VGA_ARB_WATCHDOG_EN
    logic [11:0] wd_cnt_q, wd_cnt_d;

    // Count GRANT cycles that forward no pixel; the count reaching 4095 revokes the grant
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_fire  = 1'b0;
        if (state_q == S_IDLE) begin
            wd_cnt_d = '0;
        end else if (state_q == S_GRANT && sel_req) begin
            if (sel_plot) begin
                wd_cnt_d = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 12'd1;
                wd_fire  = (wd_cnt_d == 12'hFFF);
            end
        end
    end

    // Watchdog counter register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) wd_cnt_q <= '0;
        else         wd_cnt_q <= wd_cnt_d;
    end
`else
    assign wd_fire = 1'b0;
`endif

    // Next-state logic: IDLE picks the lowest index, GRANT runs to last, req drop or watchdog, GAP idles one cycle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        plot_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        wd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    if (req[0])      grant_d = 3'b001;
                    else if (req[1]) grant_d = 3'b010;
                    else             grant_d = 3'b100;
                end
            end
            S_GRANT: begin
                if (!sel_req) begin
                    state_d = S_GAP;
                    grant_d = 3'b000;
                end else begin
                    if (sel_plot) begin
                        plot_d  = 1'b1;
                        x_d     = sel_x;
                        y_d     = sel_y;
                        color_d = sel_color;
                    end
                    if ((sel_plot && sel_last) || wd_fire) begin
                        state_d = S_GAP;
                        grant_d = 3'b000;
                        wd_d    = wd_fire;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            wd_q    <= wd_d;
        end
    end

    assign grant      = grant_q;
    assign plot       = plot_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign color      = color_q;
    assign busy       = |grant_q;
    assign wd_timeout = wd_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus random traffic against a cycle reference model.
// The model tracks owner / cooldown / idle-run in plain integers and predicts the next cycle's outputs.
// Follows the VGA_ARB_WATCHDOG_EN macro to choose the watchdog expectations.
module tb_vga_plot_arbiter;
    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;
`ifdef VGA_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             resetn;
    logic [2:0]       req, last, plot_in;
    logic [3*X_W-1:0] x_in;
    logic [3*Y_W-1:0] y_in;
    logic [3*C_W-1:0] color_in;
    logic [2:0]       grant;
    logic             plot, busy, wd_timeout;
    logic [X_W-1:0]   X;
    logic [Y_W-1:0]   Y;
    logic [C_W-1:0]   color;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int             m_owner;
    int             m_cool;
    int             m_run;
    logic           m_plot, m_wd;
    logic [X_W-1:0] m_x;
    logic [Y_W-1:0] m_y;
    logic [C_W-1:0] m_c;

    vga_plot_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
        .clock(clock), .resetn(resetn), .req(req), .last(last), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(grant), .plot(plot),
        .X(X), .Y(Y), .color(color), .busy(busy), .wd_timeout(wd_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function void model_reset();
        m_owner = -1; m_cool = 0; m_run = 0;
        m_plot = 1'b0; m_wd = 1'b0; m_x = '0; m_y = '0; m_c = '0;
    endfunction

    // Predict the outputs after the coming edge from the inputs currently applied
    function void model_step();
        bit done;
        done = 1'b0;
        m_plot = 1'b0;
        m_wd = 1'b0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) done = 1'b1;
            else if (plot_in[m_owner]) begin
                m_plot = 1'b1;
                m_x = x_in[X_W*m_owner +: X_W];
                m_y = y_in[Y_W*m_owner +: Y_W];
                m_c = color_in[C_W*m_owner +: C_W];
                m_run = 0;
                if (last[m_owner]) done = 1'b1;
            end else begin
                m_run++;
                if (WD && m_run == 4095) begin
                    done = 1'b1;
                    m_wd = 1'b1;
                end
            end
            if (done) begin
                m_owner = -1;
                m_cool = 1;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else if (req != 3'b000) begin
            for (int i = 2; i >= 0; i--) if (req[i]) m_owner = i;
            m_run = 0;
        end
    endfunction

    task automatic compare_all();
        logic [2:0] g;
        g = 3'b000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        check("grant", 32'(grant), 32'(g));
        check("busy", 32'(busy), 32'(g != 3'b000));
        check("plot", 32'(plot), 32'(m_plot));
        check("wd_timeout", 32'(wd_timeout), 32'(m_wd));
        check("xyc", {X, Y, color, 12'd0}, {m_x, m_y, m_c, 12'd0});
    endtask

    task automatic tick(input logic [2:0] r, input logic [2:0] l, input logic [2:0] p,
                        input logic [3*X_W-1:0] xs, input logic [3*Y_W-1:0] ys,
                        input logic [3*C_W-1:0] cs);
        req = r; last = l; plot_in = p; x_in = xs; y_in = ys; color_in = cs;
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle_tick(input logic [2:0] r);
        tick(r, 3'b000, 3'b000, '0, '0, '0);
    endtask

    task automatic rnd_tick();
        logic [31:0] a, b, c;
        logic [2:0] r, l;
        a = $urandom; b = $urandom; c = $urandom;
        r = 3'b000; l = 3'b000;
        for (int i = 0; i < 3; i++) begin
            r[i] = ($urandom_range(0, 7) != 0);
            l[i] = ($urandom_range(0, 7) == 0);
        end
        tick(r, l, a[2:0], b[26:0], c[23:0], a[31:23]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_out"}, {plot, busy, wd_timeout, X, Y, color}, 32'd0);
    endtask

    initial begin
        logic [3*X_W-1:0] xs;
        logic [3*Y_W-1:0] ys;
        logic [3*C_W-1:0] cs;
        int k;
        bit seen;

        resetn = 1'b0;
        req = '0; last = '0; plot_in = '0; x_in = '0; y_in = '0; color_in = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        #5 resetn = 1'b1;

        // IDLE with no request keeps grant at zero
        idle_tick(3'b000);
        idle_tick(3'b000);

        // Map outranks sprite when animation is absent; one map pixel forwarded
        idle_tick(3'b110);
        check("req110_grant", 32'(grant), 32'b010);
        idle_tick(3'b110);
        xs = '0; ys = '0; cs = '0;
        xs[X_W +: X_W] = 9'd5; ys[Y_W +: Y_W] = 8'd7; cs[C_W +: C_W] = 3'b100;
        tick(3'b110, 3'b000, 3'b010, xs, ys, cs);
        check("map_pixel", {plot, X, Y, color}, {1'b1, 9'd5, 8'd7, 3'd4});
        idle_tick(3'b000);
        check("map_release", 32'(grant), 32'd0);
        idle_tick(3'b000);

        // Sprite keeps the grant while animation requests, until its last pixel
        idle_tick(3'b100);
        check("sprite_grant", 32'(grant), 32'b100);
        xs = '0; xs[X_W*2 +: X_W] = 9'd33;
        for (int i = 0; i < 3; i++) begin
            tick(3'b101, 3'b000, 3'b101, xs, '0, '0);
            check("no_preempt", 32'(grant), 32'b100);
        end
        tick(3'b101, 3'b100, 3'b100, xs, '0, '0);
        check("sprite_last", {grant, plot, X}, {3'b000, 1'b1, 9'd33});
        idle_tick(3'b001);
        check("gap_idle", {grant, plot}, 32'd0);
        idle_tick(3'b001);
        check("anim_grant", 32'(grant), 32'b001);
        idle_tick(3'b000);
        idle_tick(3'b000);

        // Sprite strobes while map owns the port are dropped
        idle_tick(3'b010);
        xs = '0; xs[X_W*2 +: X_W] = 9'd100;
        for (int i = 0; i < 3; i++) begin
            tick(3'b110, 3'b000, 3'b100, xs, '0, '0);
            check("foreign_strobe", 32'(plot), 32'd0);
        end
        idle_tick(3'b000);
        idle_tick(3'b000);

        // Asynchronous reset in the middle of a map burst
        idle_tick(3'b010);
        for (int i = 0; i < 5; i++) begin
            xs = '0; xs[X_W +: X_W] = 9'(i + 40);
            tick(3'b010, 3'b000, 3'b010, xs, '0, '0);
        end
        #2 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        @(posedge clock);
        #1 check_all_zero("held_reset");
        #3 resetn = 1'b1;
        idle_tick(3'b010);
        check("rearbitrate", 32'(grant), 32'b010);
        idle_tick(3'b000);
        idle_tick(3'b000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) rnd_tick();
        for (int i = 0; i < 3; i++) idle_tick(3'b000);

        // Grant held with no pixels: watchdog revocation (or indefinite hold)
        idle_tick(3'b001);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 4100) begin
            k++;
            idle_tick(3'b001);
            if (wd_timeout === 1'b1) seen = 1'b1;
        end
        if (WD) begin
            check("wd_cycles", 32'(k), 32'd4095);
            check("wd_grant", 32'(grant), 32'd0);
            idle_tick(3'b001);
            check("wd_pulse_one", {wd_timeout, grant}, 32'd0);
        end else begin
            check("wd_absent", 32'(seen), 32'd0);
            check("held_grant", 32'(grant), 32'b001);
        end
        idle_tick(3'b000);
        idle_tick(3'b000);
        for (int i = 0; i < 100; i++) rnd_tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
